// File: rtl/motoro3_pwm_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motoro3_pwm_pkg
// Description : Shared constants and width helpers for the multi-channel
//               motor PWM block (default channel count and widths, the
//               carry width of the saturating remain+length add).
// Revision    : 1.0 - initial release
// ============================================================================
package motoro3_pwm_pkg;

    localparam int c_NCH_DEFAULT = 3;
    localparam int c_CW_DEFAULT  = 12;
    localparam int c_AW_DEFAULT  = 16;

    // remain + plLen needs one carry bit before it is saturated back to AW
    function automatic int sum_width(input int aw);
        return aw + 1;
    endfunction

    // Common width for comparing an AW-bit sum against CW-bit controls
    function automatic int cmp_width(input int aw, input int cw);
        return (aw > cw) ? aw : cw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/motoro3_pwm_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : motoro3_pwm_multi_if
// Description : Control/status bundle of the multi-channel PWM block. The
//               master side drives strobes, period, mask, lengths and enables;
//               the slave side (the PWM block) returns outputs and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
interface motoro3_pwm_multi_if
    import motoro3_pwm_pkg::*;
#(
    parameter int NCH = c_NCH_DEFAULT,
    parameter int CW  = c_CW_DEFAULT,
    parameter int AW  = c_AW_DEFAULT
) ();

    logic              m3cntLast1;
    logic              m3cntLast2;
    logic [CW-1:0]     m3r_pwmLenWant;
    logic [CW-1:0]     m3r_pwmMinMask;
    logic [NCH*AW-1:0] plLen;
    logic [NCH-1:0]    chEn;
    logic [NCH-1:0]    pwm;
    logic              pwmTick;
    logic [NCH*AW-1:0] posACCwant;
    logic [NCH*AW-1:0] posACCreal;

    modport master (
        output m3cntLast1, m3cntLast2, m3r_pwmLenWant, m3r_pwmMinMask, plLen, chEn,
        input  pwm, pwmTick, posACCwant, posACCreal
    );

    modport slave (
        input  m3cntLast1, m3cntLast2, m3r_pwmLenWant, m3r_pwmMinMask, plLen, chEn,
        output pwm, pwmTick, posACCwant, posACCreal
    );

endinterface
`default_nettype wire

// File: rtl/motoro3_pwm_multi_chan.sv
`default_nettype none
// ============================================================================
// Module      : motoro3_pwm_chan
// Description : One PWM channel: carries short requests forward until they
//               reach the minimum pulse length, clamps to one period, and
//               counts the on-time down. Falling-edge state.
//               Optional MOTORO3_PWM_MEAS_EN adds want/real accumulators
//               latched by the measurement-window strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module motoro3_pwm_chan
    import motoro3_pwm_pkg::*;
#(
    parameter int CW = c_CW_DEFAULT,
    parameter int AW = c_AW_DEFAULT
) (
    input  wire           clk,
    input  wire           nRst,
    input  wire           i_tick,
    input  wire           i_last2,
    input  wire [CW-1:0]  i_len_want,
    input  wire [CW-1:0]  i_min_mask,
    input  wire [AW-1:0]  i_pl_len,
    input  wire           i_en,
    output logic          o_pwm,
    output logic [AW-1:0] o_acc_want,
    output logic [AW-1:0] o_acc_real
);

    localparam int SW = sum_width(AW);
    localparam int MW = cmp_width(AW, CW);

    logic [AW-1:0] r_remain;
    logic [CW-1:0] r_on_cnt;
    logic [SW-1:0] w_sum_raw;
    logic [AW-1:0] w_sum;
    logic [MW-1:0] w_sum_x;
    logic [MW-1:0] w_mask_x;
    logic [MW-1:0] w_len_x;
    logic          w_masked;
    logic [CW-1:0] w_on_load;

    assign w_sum_raw = SW'(r_remain) + SW'(i_pl_len);
    assign w_sum     = w_sum_raw[AW] ? {AW{1'b1}} : w_sum_raw[AW-1:0];
    assign w_sum_x   = MW'(w_sum);
    assign w_mask_x  = MW'(i_min_mask);
    assign w_len_x   = MW'(i_len_want);
    assign w_masked  = (w_sum_x < w_mask_x);
    // Anything beyond one period is dropped, not carried
    assign w_on_load = (w_sum_x > w_len_x) ? i_len_want : w_sum_x[CW-1:0];

    // Remain/on-count update: disable clears, tick reloads, else count down
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            r_remain <= '0;
            r_on_cnt <= '0;
        end else if (!i_en) begin
            r_remain <= '0;
            r_on_cnt <= '0;
        end else if (i_tick) begin
            if (w_masked) begin
                r_remain <= w_sum;
                r_on_cnt <= '0;
            end else begin
                r_remain <= '0;
                r_on_cnt <= w_on_load;
            end
        end else if (r_on_cnt != '0) begin
            r_on_cnt <= r_on_cnt - CW'(1);
        end
    end

    assign o_pwm = (r_on_cnt != '0);

`ifdef MOTORO3_PWM_MEAS_EN
    logic [AW-1:0] r_want_acc;
    logic [AW-1:0] r_real_acc;
    logic [AW-1:0] r_want_q;
    logic [AW-1:0] r_real_q;

    // Window close snapshots and clears; an increment on that clock is lost
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            r_want_acc <= '0;
            r_real_acc <= '0;
            r_want_q   <= '0;
            r_real_q   <= '0;
        end else if (i_last2) begin
            r_want_q   <= r_want_acc;
            r_real_q   <= r_real_acc;
            r_want_acc <= '0;
            r_real_acc <= '0;
        end else begin
            if (i_tick) begin
                r_want_acc <= r_want_acc + i_pl_len;
            end
            if (o_pwm) begin
                r_real_acc <= r_real_acc + AW'(1);
            end
        end
    end

    assign o_acc_want = r_want_q;
    assign o_acc_real = r_real_q;
`else
    logic w_unused_last2;
    assign w_unused_last2 = i_last2;
    assign o_acc_want     = '0;
    assign o_acc_real     = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/motoro3_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : motoro3_pwm_multi
// Description : Multi-channel motor PWM. A shared period counter produces
//               one tick per period; each channel turns its requested
//               on-length into a pulse starting at the tick. Falling-edge
//               state, asynchronous active-low reset.
//               Optional MOTORO3_PWM_MEAS_EN enables per-channel statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module motoro3_pwm_multi
    import motoro3_pwm_pkg::*;
#(
    parameter int NCH = c_NCH_DEFAULT,
    parameter int CW  = c_CW_DEFAULT,
    parameter int AW  = c_AW_DEFAULT
) (
    input  wire               clk,
    input  wire               nRst,
    motoro3_pwm_multi_if.slave bus
);

    logic [CW-1:0]     r_pwm_cnt;
    logic              r_reload_d;
    logic              w_reload;
    logic              w_tick;
    logic [NCH-1:0]    w_pwm;
    logic [NCH*AW-1:0] w_acc_want;
    logic [NCH*AW-1:0] w_acc_real;

    assign w_reload = bus.m3cntLast1 | (r_pwm_cnt <= CW'(1));
    // A run of reload clocks yields a single tick on its trailing edge
    assign w_tick   = r_reload_d & ~w_reload;

    // Shared period counter and reload history
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            r_pwm_cnt  <= bus.m3r_pwmLenWant;
            r_reload_d <= 1'b0;
        end else begin
            r_reload_d <= w_reload;
            r_pwm_cnt  <= w_reload ? bus.m3r_pwmLenWant : (r_pwm_cnt - CW'(1));
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        motoro3_pwm_chan #(
            .CW (CW),
            .AW (AW)
        ) u_chan (
            .clk        (clk),
            .nRst       (nRst),
            .i_tick     (w_tick),
            .i_last2    (bus.m3cntLast2),
            .i_len_want (bus.m3r_pwmLenWant),
            .i_min_mask (bus.m3r_pwmMinMask),
            .i_pl_len   (bus.plLen[gi*AW +: AW]),
            .i_en       (bus.chEn[gi]),
            .o_pwm      (w_pwm[gi]),
            .o_acc_want (w_acc_want[gi*AW +: AW]),
            .o_acc_real (w_acc_real[gi*AW +: AW])
        );
    end

    assign bus.pwm        = w_pwm;
    assign bus.pwmTick    = w_tick;
    assign bus.posACCwant = w_acc_want;
    assign bus.posACCreal = w_acc_real;

endmodule
`default_nettype wire

// File: tb/tb_motoro3_pwm_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_motoro3_pwm_multi
// Description : Directed self-checking bench for motoro3_pwm_multi. State
//               moves on the falling edge; the bench samples and drives just
//               after the rising edge. Covers MOTORO3_PWM_MEAS_EN both ways.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motoro3_pwm_multi;
    import motoro3_pwm_pkg::*;

    localparam int NCH = 3;
    localparam int CW  = 12;
    localparam int AW  = 16;
`ifdef MOTORO3_PWM_MEAS_EN
    localparam bit MEAS = 1'b1;
`else
    localparam bit MEAS = 1'b0;
`endif

    logic clk  = 1'b0;
    logic nRst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   hi [NCH];

    motoro3_pwm_multi_if #(.NCH(NCH), .CW(CW), .AW(AW)) bus ();

    motoro3_pwm_multi #(.NCH(NCH), .CW(CW), .AW(AW)) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    always #50 clk = ~clk;

    task automatic set_pl(input int ch, input int val);
        bus.plLen[ch*AW +: AW] = AW'(val);
    endtask

    // Advance to the next tick, counting clocks and per-channel high clocks
    task automatic run_to_tick(input int budget, output int n);
        n = 0;
        for (int c = 0; c < NCH; c++) hi[c] = 0;
        do begin
            @(posedge clk);
            n++;
            for (int c = 0; c < NCH; c++) if (bus.pwm[c]) hi[c]++;
        end while (bus.pwmTick !== 1'b1 && n < budget);
        if (bus.pwmTick !== 1'b1) begin
            checks++; errors++;
            $display("FAIL tick_timeout: no pwmTick within %0d clocks", budget);
        end
    endtask

    task automatic test_reset();
        int n;
        repeat (3) @(posedge clk);
        checks++; if (bus.pwm !== 3'b000 || bus.pwmTick !== 1'b0) begin errors++;
            $display("FAIL reset_out: pwm=%b tick=%b want 000/0", bus.pwm, bus.pwmTick); end
        checks++; if (bus.posACCwant !== '0 || bus.posACCreal !== '0) begin errors++;
            $display("FAIL reset_acc: want=%h real=%h want 0", bus.posACCwant, bus.posACCreal); end
        nRst = 1'b1;
        run_to_tick(300, n);
        checks++; if (n != 100) begin errors++;
            $display("FAIL first_tick: got %0d clocks want 100", n); end
        checks++; if (hi[0] + hi[1] + hi[2] != 0) begin errors++;
            $display("FAIL pre_tick_pwm: got %0d high clocks want 0", hi[0] + hi[1] + hi[2]); end
    endtask

    task automatic test_basic();
        int n;
        run_to_tick(300, n);
        checks++; if (n != 100) begin errors++; $display("FAIL basic_period: got %0d want 100", n); end
        checks++; if (hi[0] != 40) begin errors++; $display("FAIL basic_ch0: got %0d want 40", hi[0]); end
        checks++; if (hi[1] != 60) begin errors++; $display("FAIL basic_ch1: got %0d want 60", hi[1]); end
        checks++; if (hi[2] != 0) begin errors++; $display("FAIL basic_ch2: got %0d want 0", hi[2]); end
    endtask

    task automatic test_mask();
        int n;
        int exp0 [4] = '{0, 40, 0, 40};
        set_pl(0, 20);
        set_pl(1, 32);
        for (int p = 0; p < 4; p++) begin
            run_to_tick(300, n);
            checks++; if (hi[0] != exp0[p]) begin errors++;
                $display("FAIL mask_ch0 period %0d: got %0d want %0d", p, hi[0], exp0[p]); end
            checks++; if (hi[1] != 32) begin errors++;
                $display("FAIL mask_edge_ch1 period %0d: got %0d want 32", p, hi[1]); end
        end
        bus.m3r_pwmMinMask = '0;
        set_pl(0, 5);
        run_to_tick(300, n);
        checks++; if (hi[0] != 5) begin errors++; $display("FAIL nomask_ch0: got %0d want 5", hi[0]); end
        checks++; if (hi[2] != 0) begin errors++; $display("FAIL zero_len_ch2: got %0d want 0", hi[2]); end
        bus.m3r_pwmMinMask = CW'(32);
    endtask

    task automatic test_clamp();
        int n;
        set_pl(0, 150);
        set_pl(1, 60);
        for (int p = 0; p < 2; p++) begin
            run_to_tick(300, n);
            checks++; if (hi[0] != 100 || n != 100) begin errors++;
                $display("FAIL clamp period %0d: high %0d period %0d want 100/100", p, hi[0], n); end
        end
    endtask

    task automatic test_chen();
        int n;
        repeat (44) @(posedge clk);
        checks++; if (bus.pwm[1] !== 1'b1) begin errors++;
            $display("FAIL chen_before: pwm1=%b want 1", bus.pwm[1]); end
        bus.chEn = 3'b101;
        @(posedge clk);
        checks++; if (bus.pwm[1] !== 1'b0 || bus.pwm[0] !== 1'b1) begin errors++;
            $display("FAIL chen_drop: pwm=%b want x01 with pwm1=0 pwm0=1", bus.pwm); end
        run_to_tick(300, n);
        checks++; if (n != 55) begin errors++; $display("FAIL chen_rest: got %0d want 55", n); end
        run_to_tick(300, n);
        checks++; if (hi[1] != 0 || hi[0] != 100) begin errors++;
            $display("FAIL chen_off: ch1 %0d ch0 %0d want 0/100", hi[1], hi[0]); end
        bus.chEn = 3'b111;
        run_to_tick(300, n);
        checks++; if (hi[1] != 60) begin errors++; $display("FAIL chen_on: got %0d want 60", hi[1]); end
    endtask

    task automatic test_resync();
        int  n  = 0;
        int  h1 = 0;
        bit  seen = 1'b0;
        while (!seen && n < 300) begin
            @(posedge clk);
            n++;
            if (bus.pwm[1]) h1++;
            if (n >= 12 && bus.pwmTick === 1'b1) seen = 1'b1;
            if (n == 10) bus.m3cntLast1 = 1'b1;
            if (n == 11) bus.m3cntLast1 = 1'b0;
        end
        checks++; if (!seen || n != 111) begin errors++;
            $display("FAIL resync_period: got %0d seen %0d want 111", n, seen); end
        checks++; if (h1 != 71) begin errors++; $display("FAIL resync_pulse: got %0d want 71", h1); end
    endtask

    task automatic test_lenwant_small();
        int ticks = 0;
        int highs = 0;
        bus.m3r_pwmLenWant = CW'(1);
        @(posedge clk);
        checks++; if (bus.pwm !== 3'b011) begin errors++;
            $display("FAIL len1_clamp: pwm=%b want 011", bus.pwm); end
        @(posedge clk);
        for (int i = 0; i < 250; i++) begin
            if (bus.pwmTick === 1'b1) ticks++;
            if (bus.pwm !== 3'b000) highs++;
            @(posedge clk);
        end
        checks++; if (ticks != 0) begin errors++; $display("FAIL len1_ticks: got %0d want 0", ticks); end
        checks++; if (highs != 0) begin errors++; $display("FAIL len1_pwm: got %0d want 0", highs); end
    endtask

    task automatic test_reset_midpulse();
        int n;
        bus.m3r_pwmLenWant = CW'(100);
        run_to_tick(300, n);
        checks++; if (n != 1) begin errors++; $display("FAIL relen_tick: got %0d want 1", n); end
        repeat (5) @(posedge clk);
        checks++; if (bus.pwm !== 3'b011) begin errors++;
            $display("FAIL midpulse: pwm=%b want 011", bus.pwm); end
        nRst = 1'b0;
        #1;
        checks++; if (bus.pwm !== 3'b000 || bus.pwmTick !== 1'b0) begin errors++;
            $display("FAIL async_reset: pwm=%b tick=%b want 000/0", bus.pwm, bus.pwmTick); end
        repeat (3) @(posedge clk);
        nRst = 1'b1;
        run_to_tick(300, n);
        checks++; if (n != 100 || hi[0] + hi[1] != 0) begin errors++;
            $display("FAIL post_reset: period %0d highs %0d want 100/0", n, hi[0] + hi[1]); end
        run_to_tick(300, n);
        checks++; if (hi[0] != 100 || hi[1] != 60) begin errors++;
            $display("FAIL post_reset_pulse: ch0 %0d ch1 %0d want 100/60", hi[0], hi[1]); end
    endtask

    task automatic test_meas();
        @(posedge clk);
        nRst = 1'b0;
        set_pl(0, 40);
        set_pl(1, 45);
        set_pl(2, 0);
        repeat (2) @(posedge clk);
        nRst = 1'b1;
        repeat (550) @(posedge clk);
        bus.m3cntLast2 = 1'b1;
        @(posedge clk);
        bus.m3cntLast2 = 1'b0;
        checks++; if (bus.posACCwant[AW-1:0] !== AW'(MEAS ? 200 : 0) || bus.posACCreal[AW-1:0] !== AW'(MEAS ? 200 : 0)) begin
            errors++; $display("FAIL meas5_ch0: want=%0d real=%0d want %0d", bus.posACCwant[AW-1:0], bus.posACCreal[AW-1:0], MEAS ? 200 : 0); end
        checks++; if (bus.posACCwant[2*AW-1:AW] !== AW'(MEAS ? 225 : 0) || bus.posACCreal[2*AW-1:AW] !== AW'(MEAS ? 225 : 0)) begin
            errors++; $display("FAIL meas5_ch1: want=%0d real=%0d want %0d", bus.posACCwant[2*AW-1:AW], bus.posACCreal[2*AW-1:AW], MEAS ? 225 : 0); end
        repeat (49) @(posedge clk);
        checks++; if (bus.pwmTick !== 1'b1) begin errors++;
            $display("FAIL meas_tick600: tick=%b want 1", bus.pwmTick); end
        bus.m3cntLast2 = 1'b1;
        @(posedge clk);
        bus.m3cntLast2 = 1'b0;
        checks++; if (bus.posACCwant[AW-1:0] !== '0 || bus.posACCreal[AW-1:0] !== '0) begin errors++;
            $display("FAIL meas_coinc: want=%0d real=%0d want 0/0", bus.posACCwant[AW-1:0], bus.posACCreal[AW-1:0]); end
        repeat (49) @(posedge clk);
        bus.m3cntLast2 = 1'b1;
        @(posedge clk);
        bus.m3cntLast2 = 1'b0;
        checks++; if (bus.posACCwant[AW-1:0] !== '0 || bus.posACCreal[AW-1:0] !== AW'(MEAS ? 40 : 0)) begin
            errors++; $display("FAIL meas_lost: want=%0d real=%0d want 0/%0d", bus.posACCwant[AW-1:0], bus.posACCreal[AW-1:0], MEAS ? 40 : 0); end
        checks++; if (bus.posACCwant[2*AW-1:AW] !== '0 || bus.posACCreal[2*AW-1:AW] !== AW'(MEAS ? 45 : 0)) begin
            errors++; $display("FAIL meas_lost_ch1: want=%0d real=%0d want 0/%0d", bus.posACCwant[2*AW-1:AW], bus.posACCreal[2*AW-1:AW], MEAS ? 45 : 0); end
    endtask

    initial begin
        bus.m3cntLast1     = 1'b0;
        bus.m3cntLast2     = 1'b0;
        bus.m3r_pwmLenWant = CW'(100);
        bus.m3r_pwmMinMask = CW'(32);
        bus.plLen          = '0;
        set_pl(0, 40);
        set_pl(1, 60);
        set_pl(2, 0);
        bus.chEn           = 3'b111;
        test_reset();
        test_basic();
        test_mask();
        test_clamp();
        test_chen();
        test_resync();
        test_lenwant_small();
        test_reset_midpulse();
        test_meas();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/motoro3_pwm_multi.md
MOTORO3_PWM_MULTI -- requirements
Module: motoro3_pwm_multi

Interface
REQ-001 Parameter NCH, default 3: number of PWM channels, 1..8.
REQ-002 Parameter CW, default 12: width of the period counter and of the min-pulse mask.
REQ-003 Parameter AW, default 16: width of the on-length, remainder and accumulator values.
REQ-004 clk  input  1  sole clock, 10 MHz; all state SHALL update on the falling edge.
REQ-005 nRst  input  1  reset, asynchronous, active-low.
REQ-006 m3cntLast1  input  1  period resync strobe.
REQ-007 m3cntLast2  input  1  measurement-window close strobe.
REQ-008 m3r_pwmLenWant  input  CW  PWM period in clocks.
REQ-009 m3r_pwmMinMask  input  CW  minimum emitted pulse length in clocks.
REQ-010 plLen  input  NCH*AW  requested on-clocks per period; channel i is at [i*AW +: AW].
REQ-011 chEn  input  NCH  per-channel enable.
REQ-012 pwm  output  NCH  per-channel PWM output.
REQ-013 pwmTick  output  1  one-clock pulse at each period start.
REQ-014 posACCwant  output  NCH*AW  per-channel requested on-clocks, latched per measurement window.
REQ-015 posACCreal  output  NCH*AW  per-channel delivered on-clocks, latched per measurement window.

Function
REQ-016 Period counter pwmCNT (CW bits) SHALL reload with m3r_pwmLenWant when reload = m3cntLast1 | (pwmCNT<=1); otherwise it SHALL decrement by 1.
REQ-017 reloadD SHALL be reload registered one clock; pwmTick SHALL equal reloadD & ~reload, so consecutive reload clocks produce a single tick.
REQ-018 At pwmTick, each channel SHALL form sum = remain + plLen_i, AW+1 bits wide, saturated to 2^AW-1.
REQ-019 If sum < m3r_pwmMinMask (zero-extended), the channel SHALL set remain = sum and onCnt = 0, skipping the pulse and carrying the length forward.
REQ-020 Otherwise the channel SHALL set remain = 0 and onCnt = min(sum, m3r_pwmLenWant); any excess beyond one period SHALL be discarded.
REQ-021 When not at pwmTick, onCnt SHALL decrement while nonzero and hold at 0.
REQ-022 pwm[i] SHALL equal (onCnt_i != 0) with 0 clocks of latency, i.e. high for exactly onCnt clocks after the tick edge.
REQ-023 While chEn[i]=0, the channel SHALL force onCnt_i = 0 and remain_i = 0 every clock.
REQ-024 m3cntLast1 arriving mid-pulse SHALL NOT truncate the pulse until the following pwmTick reloads onCnt.
REQ-025 m3r_pwmMinMask = 0 SHALL disable masking; plLen_i = 0 with remain = 0 SHALL yield no pulse.
REQ-026 m3r_pwmLenWant = 0 or 1 SHALL reload every clock and produce no ticks after the first; pwm SHALL then remain at 0.

Reset
REQ-027 While nRst=0: pwmCNT = m3r_pwmLenWant; reloadD, remain, onCnt and accumulators = 0; pwm, pwmTick, posACCwant and posACCreal = 0.
REQ-028 Reset deasserted mid-pulse SHALL leave no residual pulse; the first pulse SHALL follow the first pwmTick.

Configuration
REQ-029 With macro MOTORO3_PWM_MEAS_EN defined, each channel SHALL keep wantAcc (+= plLen_i at pwmTick) and realAcc (+= 1 per clock with pwm[i]=1), both AW-bit wrapping.
REQ-030 With MOTORO3_PWM_MEAS_EN defined, m3cntLast2 SHALL copy the accumulators to posACCwant/posACCreal and clear them; clear SHALL win over a coincident increment, which is lost.
REQ-031 Without MOTORO3_PWM_MEAS_EN, the accumulators SHALL be absent and posACCwant/posACCreal SHALL be tied to 0.

Structure
REQ-032 Package motoro3_pwm_pkg SHALL hold the default NCH/CW/AW constants and the saturating-add width rule.
REQ-033 Per-channel logic (remain, onCnt, mask, clamp, accumulators) SHALL be sub-module motoro3_pwm_chan, instantiated NCH times by generate.
REQ-034 The period counter and tick logic SHALL stay in the top module and be shared by all channels.

Verification
REQ-035 LenWant=100, MinMask=32, plLen0=40 -> pwm[0] high 40 clocks per tick, period 100 clocks.
REQ-036 MinMask=32, plLen0=20 -> tick1 no pulse (remain 20); tick2 pulse 40; tick3 no pulse; repeating.
REQ-037 LenWant=100, plLen0=150 -> pulse clamped to 100 clocks every period; remain stays 0.
REQ-038 chEn[1] dropped mid-pulse (onCnt=17) -> pwm[1] low next clock; other channels unaffected.
REQ-039 MEAS_EN, plLen0=40, m3cntLast2 after 5 ticks -> posACCwant0=200, posACCreal0=200; m3cntLast2 coincident with a tick -> that increment lost.
REQ-040 nRst pulsed low during an active pulse -> all outputs 0 immediately; first new pulse only after the next pwmTick.
